mac_tx_crc_append: RTL

Transmit-side MAC framer. It accepts a byte stream from the network layer with a valid/ready/last handshake. Each frame starts at the destination MAC and ends at the last payload byte. The block emits a GMII-style byte stream to the PHY: it prepends preamble/SFD, zero-pads short frames to the Ethernet minimum, appends a CRC-32 FCS, and enforces the inter-frame gap. It is the outbound counterpart of the MAC receive CRC-verify path and runs entirely in the logic clock domain.

---
 rtl/mac_tx_crc_append.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mac_tx_crc_append.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_crc_append
// Purpose  : Transmit-side MAC framer. Takes a frame (destination MAC up to
//            the last payload byte) over a valid/ready/last byte stream,
//            prepends preamble/SFD, zero-pads short frames to
//            MIN_FRAME_BYTES, appends the CRC-32 FCS and enforces an
//            IFG_BYTES idle gap after every frame (including aborted ones).
//            A source underrun mid-frame poisons the frame with one
//            err-flagged byte and drains the rest of the frame.
// Ports    : logic_clk           - single clock, one byte per cycle
//            logic_rst           - asynchronous, active-low reset
//            mac_rnet_data_in    - frame byte from network layer
//            mac_rnet_valid_in   - byte valid
//            mac_rnet_ready_out  - byte accepted when valid && ready
//            mac_rnet_last_in    - final byte of the frame
//            mac_tphy_data_out   - byte to PHY (registered)
//            mac_tphy_valid_out  - PHY transmit enable (registered)
//            mac_tphy_err_out    - PHY transmit error (registered)
// Revision : 1.0 - initial release
// ============================================================================
module mac_tx_crc_append #(
   parameter int IFG_BYTES       = 12,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic       logic_clk,
   input  logic       logic_rst,
   input  logic [7:0] mac_rnet_data_in,
   input  logic       mac_rnet_valid_in,
   output logic       mac_rnet_ready_out,
   input  logic       mac_rnet_last_in,
   output logic [7:0] mac_tphy_data_out,
   output logic       mac_tphy_valid_out,
   output logic       mac_tphy_err_out
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_DATA = 3'd2,
      ST_PAD  = 3'd3,
      ST_FCS  = 3'd4,
      ST_DROP = 3'd5,
      ST_IFG  = 3'd6
   } state_t;

   localparam logic [31:0] c_crc_poly  = 32'hEDB88320;
   localparam logic [31:0] c_crc_init  = 32'hFFFFFFFF;
   localparam logic [7:0]  c_preamble  = 8'h55;
   localparam logic [7:0]  c_sfd       = 8'hD5;
   localparam logic [11:0] c_min_bytes = 12'(MIN_FRAME_BYTES);
   localparam int          c_ifg_w     = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
   localparam logic [c_ifg_w-1:0] c_ifg_last = c_ifg_w'(IFG_BYTES - 1);

   state_t             r_state;
   logic [2:0]         r_pre_cnt;
   logic [1:0]         r_fcs_cnt;
   logic [c_ifg_w-1:0] r_ifg_cnt;
   logic [10:0]        r_byte_cnt;
   logic [31:0]        r_crc;

   logic [31:0] w_crc_data;
   logic [31:0] w_crc_pad;
   logic [31:0] w_fcs;
   logic [7:0]  w_fcs_byte;
   logic [11:0] w_cnt_inc;
   logic [10:0] w_cnt_sat;

   // Reflected CRC-32, one byte per call: the byte enters at the LSB end.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
      end
      return c;
   endfunction

   // Ready is decoded from state so the source sees it drop the moment the
   // FSM leaves DATA/DROP (and immediately on async reset).
   assign mac_rnet_ready_out = (r_state == ST_DATA) || (r_state == ST_DROP);

   assign w_crc_data = crc32_byte(r_crc, mac_rnet_data_in);
   assign w_crc_pad  = crc32_byte(r_crc, 8'h00);
   assign w_fcs      = ~r_crc;
   // Unsaturated count including the current byte, used for the pad decision.
   assign w_cnt_inc  = {1'b0, r_byte_cnt} + 12'd1;
   assign w_cnt_sat  = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : (r_byte_cnt + 11'd1);

   // FCS goes out least-significant byte first.
   always_comb begin
      w_fcs_byte = w_fcs[7:0];
      case (r_fcs_cnt)
         2'd0:    w_fcs_byte = w_fcs[7:0];
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         default: w_fcs_byte = w_fcs[31:24];
      endcase
   end

   always_ff @(posedge logic_clk or negedge logic_rst) begin
      if (!logic_rst) begin
         r_state            <= ST_IDLE;
         r_pre_cnt          <= 3'd0;
         r_fcs_cnt          <= 2'd0;
         r_ifg_cnt          <= '0;
         r_byte_cnt         <= 11'd0;
         r_crc              <= c_crc_init;
         mac_tphy_data_out  <= 8'h00;
         mac_tphy_valid_out <= 1'b0;
         mac_tphy_err_out   <= 1'b0;
      end else begin
         mac_tphy_data_out  <= 8'h00;
         mac_tphy_valid_out <= 1'b0;
         mac_tphy_err_out   <= 1'b0;

         case (r_state)
            // The first preamble byte leaves on the same edge that sees
            // valid, so the preamble counter starts at 1 in PRE.
            ST_IDLE: begin
               if (mac_rnet_valid_in) begin
                  mac_tphy_data_out  <= c_preamble;
                  mac_tphy_valid_out <= 1'b1;
                  r_pre_cnt          <= 3'd1;
                  r_crc              <= c_crc_init;
                  r_byte_cnt         <= 11'd0;
                  r_state            <= ST_PRE;
               end
            end

            ST_PRE: begin
               mac_tphy_valid_out <= 1'b1;
               mac_tphy_data_out  <= (r_pre_cnt == 3'd7) ? c_sfd : c_preamble;
               r_pre_cnt          <= r_pre_cnt + 3'd1;
               if (r_pre_cnt == 3'd7) begin
                  r_state <= ST_DATA;
               end
            end

            ST_DATA: begin
               mac_tphy_valid_out <= 1'b1;
               if (mac_rnet_valid_in) begin
                  mac_tphy_data_out <= mac_rnet_data_in;
                  r_crc             <= w_crc_data;
                  r_byte_cnt        <= w_cnt_sat;
                  if (mac_rnet_last_in) begin
                     r_fcs_cnt <= 2'd0;
                     r_state   <= (w_cnt_inc < c_min_bytes) ? ST_PAD : ST_FCS;
                  end
               end else begin
                  // Source starved mid-frame: poison the frame on the wire.
                  mac_tphy_data_out <= 8'h00;
                  mac_tphy_err_out  <= 1'b1;
                  r_state           <= ST_DROP;
               end
            end

            ST_PAD: begin
               mac_tphy_valid_out <= 1'b1;
               mac_tphy_data_out  <= 8'h00;
               r_crc              <= w_crc_pad;
               r_byte_cnt         <= w_cnt_sat;
               if (w_cnt_inc == c_min_bytes) begin
                  r_fcs_cnt <= 2'd0;
                  r_state   <= ST_FCS;
               end
            end

            ST_FCS: begin
               mac_tphy_valid_out <= 1'b1;
               mac_tphy_data_out  <= w_fcs_byte;
               r_fcs_cnt          <= r_fcs_cnt + 2'd1;
               if (r_fcs_cnt == 2'd3) begin
                  r_ifg_cnt <= '0;
                  r_state   <= ST_IFG;
               end
            end

            ST_DROP: begin
               if (mac_rnet_valid_in && mac_rnet_last_in) begin
                  r_ifg_cnt <= '0;
                  r_state   <= ST_IFG;
               end
            end

            ST_IFG: begin
               if (r_ifg_cnt == c_ifg_last) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_ifg_cnt <= r_ifg_cnt + 1'b1;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
